// File: rtl/uart_byte_receiver_pkg.sv
// uart_byte_receiver_pkg: UART constants and receiver FSM encoding shared with the tx side
package uart_byte_receiver_pkg;
    localparam int UART_DATA_BITS          = 8;
    localparam int DELAY_FRAMES_27M_115200 = 234;

    typedef enum logic [2:0] {
        RX_IDLE  = 3'd0,
        RX_START = 3'd1,
        RX_DATA  = 3'd2,
        RX_STOP  = 3'd3,
        RX_BREAK = 3'd4
    } rx_state_e;
endpackage

// File: rtl/uart_byte_receiver_if.sv
// uart_byte_receiver_if: received-byte valid/ready stream plus status flags
interface uart_byte_receiver_if;
    import uart_byte_receiver_pkg::*;
    logic [UART_DATA_BITS-1:0] rx_data;
    logic                      rx_valid;
    logic                      rx_ready;
    logic                      frame_err;
    logic                      overrun;
    logic                      busy;
    modport master (output rx_data, rx_valid, frame_err, overrun, busy, input rx_ready);
    modport slave  (input rx_data, rx_valid, frame_err, overrun, busy, output rx_ready);
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word fall-through FIFO; pointers carry an extra wrap bit
module uart_rx_fifo
    import uart_byte_receiver_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int FIFO_AW    = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      push_i,
    input  logic [UART_DATA_BITS-1:0] data_i,
    input  logic                      pop_i,
    output logic [UART_DATA_BITS-1:0] data_o,
    output logic                      full_o,
    output logic                      empty_o
);
    logic [UART_DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [FIFO_AW:0]          wr_q, rd_q;

    assign empty_o = wr_q == rd_q;
    assign full_o  = (wr_q[FIFO_AW] != rd_q[FIFO_AW]) && (wr_q[FIFO_AW-1:0] == rd_q[FIFO_AW-1:0]);
    assign data_o  = empty_o ? '0 : mem_q[rd_q[FIFO_AW-1:0]];

    // pointer advance; a pop on an empty FIFO is ignored
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (push_i) wr_q <= wr_q + 1'b1;
            if (pop_i && !empty_o) rd_q <= rd_q + 1'b1;
        end
    end

    // storage write; contents are only visible while not empty
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_q[FIFO_AW-1:0]] <= data_i;
    end
endmodule

// File: rtl/uart_byte_receiver.sv
// uart_byte_receiver: 8N1 LSB-first UART receiver feeding a small FWFT FIFO
module uart_byte_receiver
    import uart_byte_receiver_pkg::*;
#(
    parameter int DELAY_FRAMES = DELAY_FRAMES_27M_115200,
    parameter int FIFO_DEPTH   = 4,
    parameter int FIFO_AW      = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   uart_rx_i,
    uart_byte_receiver_if.master   bus
);
    localparam int CW = $clog2(DELAY_FRAMES);

    rx_state_e                 state_q, state_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [2:0]                bit_q, bit_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic                      meta_q, rxs_q;
    logic                      frame_err_q, overrun_q;
    logic                      stop_ok, stop_bad, full, empty, pop, push;

    assign pop           = !empty && bus.rx_ready;
    assign push          = stop_ok && (!full || pop);
    assign bus.rx_valid  = !empty;
    assign bus.frame_err = frame_err_q;
    assign bus.overrun   = overrun_q;
    assign bus.busy      = state_q != RX_IDLE;

    // two-flop synchroniser on the raw line, idle-high reset value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            rxs_q  <= 1'b1;
        end else begin
            meta_q <= uart_rx_i;
            rxs_q  <= meta_q;
        end
    end

    // receiver state, bit timing, shift register and registered error pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RX_IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            frame_err_q <= stop_bad;
            overrun_q   <= stop_ok && full && !pop;
        end
    end

    // next state: half-bit wait into the start bit, then one sample per bit period
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + 1'b1;
        bit_d    = bit_q;
        shift_d  = shift_q;
        stop_ok  = 1'b0;
        stop_bad = 1'b0;
        case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (!rxs_q) state_d = RX_START;
            end
            RX_START: if (cnt_q == CW'(DELAY_FRAMES / 2 - 1)) begin
                cnt_d   = '0;
                bit_d   = '0;
                state_d = rxs_q ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (cnt_q == CW'(DELAY_FRAMES - 1)) begin
                cnt_d          = '0;
                shift_d[bit_q] = rxs_q;
                bit_d          = bit_q + 3'd1;
                if (bit_q == 3'(UART_DATA_BITS - 1)) state_d = RX_STOP;
            end
            RX_STOP: if (cnt_q == CW'(DELAY_FRAMES - 1)) begin
                cnt_d    = '0;
                stop_ok  = rxs_q;
                stop_bad = !rxs_q;
                state_d  = rxs_q ? RX_IDLE : RX_BREAK;
            end
            RX_BREAK: begin
                cnt_d = '0;
                if (rxs_q) state_d = RX_IDLE;
            end
            default: state_d = RX_IDLE;
        endcase
    end

    uart_rx_fifo #(.FIFO_DEPTH(FIFO_DEPTH), .FIFO_AW(FIFO_AW)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .data_i  (shift_q),
        .pop_i   (pop),
        .data_o  (bus.rx_data),
        .full_o  (full),
        .empty_o (empty)
    );
endmodule

// File: tb/tb_uart_byte_receiver.sv
// tb_uart_byte_receiver: directed and random frames checked against a queue-based receive model
module tb_uart_byte_receiver;
    localparam int DF = 16;
    localparam int BT = DF * 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic uart_rx = 1'b1;
    int n_chk = 0;
    int n_fail = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int both_cnt = 0;
    int exp_fe = 0;
    int exp_ov = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    uart_byte_receiver_if bus();

    uart_byte_receiver #(.DELAY_FRAMES(DF), .FIFO_DEPTH(4), .FIFO_AW(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .uart_rx_i (uart_rx),
        .bus       (bus)
    );

    // flag pulse counters, sampled away from the active edge
    always @(negedge clk) begin
        if (bus.frame_err) fe_cnt++;
        if (bus.overrun) ov_cnt++;
        if (bus.frame_err && bus.overrun) both_cnt++;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout, expected test completion");
        $fatal(1);
    end

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop, input int bt);
        uart_rx = 1'b0;
        #bt;
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            #bt;
        end
        uart_rx = stop;
        #bt;
    endtask

    // receive model: what a stop-bit sample does to the FIFO and flags
    task automatic model_rx(input logic [7:0] b, input bit stop_ok, input bit popped);
        if (!stop_ok) exp_fe++;
        else if (exp_q.size() >= 4 && !popped) exp_ov++;
        else exp_q.push_back(b);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        int exp_n = exp_q.size();
        @(negedge clk);
        bus.rx_ready = 1'b1;
        for (int i = 0; i < 16 && bus.rx_valid; i++) begin
            n++;
            if (exp_q.size() > 0) check({tag, "_data"}, bus.rx_data, exp_q.pop_front());
            @(negedge clk);
        end
        bus.rx_ready = 1'b0;
        check({tag, "_count"}, n, exp_n);
        check({tag, "_empty"}, bus.rx_valid, 0);
    endtask

    task automatic check_flags(input string tag);
        check({tag, "_frame_err_cnt"}, fe_cnt, exp_fe);
        check({tag, "_overrun_cnt"}, ov_cnt, exp_ov);
    endtask

    initial begin
        logic [7:0] b;
        logic [7:0] seq[3];
        int n;
        bus.rx_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid", bus.rx_valid, 0);
        check("rst_busy", bus.busy, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_data", bus.rx_data, 0);
        check("rst_valid_rel", bus.rx_valid, 0);
        check("rst_frame_err", bus.frame_err, 0);
        check("rst_overrun", bus.overrun, 0);
        check("rst_busy_rel", bus.busy, 0);

        // 1: single byte, latency to rxValid
        repeat (5) @(negedge clk);
        fork
            send_byte(8'hA5, 1'b1, BT);
            begin
                repeat (154) @(negedge clk);
                check("t1_valid_before", bus.rx_valid, 0);
                check("t1_busy", bus.busy, 1);
                @(negedge clk);
                check("t1_valid_after", bus.rx_valid, 1);
                check("t1_data", bus.rx_data, 8'hA5);
            end
        join
        model_rx(8'hA5, 1'b1, 1'b0);
        check_flags("t1");
        drain("t1");

        // 2: back-to-back bytes popped in order
        seq[0] = 8'h00; seq[1] = 8'hFF; seq[2] = 8'h3C;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            send_byte(seq[i], 1'b1, BT);
            model_rx(seq[i], 1'b1, 1'b0);
        end
        repeat (4) @(negedge clk);
        drain("t2");
        check_flags("t2");

        // 3a: fifth byte into a full FIFO overruns
        @(negedge clk);
        for (int i = 1; i <= 5; i++) begin
            send_byte(8'(i), 1'b1, BT);
            model_rx(8'(i), 1'b1, 1'b0);
        end
        repeat (4) @(negedge clk);
        check_flags("t3a");
        drain("t3a");

        // 3b: pop on the same edge as the fifth stop sample avoids overrun
        @(negedge clk);
        for (int i = 1; i <= 4; i++) begin
            send_byte(8'(i), 1'b1, BT);
            model_rx(8'(i), 1'b1, 1'b0);
        end
        @(negedge clk);
        fork
            send_byte(8'h05, 1'b1, BT);
            begin
                repeat (154) @(negedge clk);
                bus.rx_ready = 1'b1;
                check("t3b_head", bus.rx_data, exp_q.pop_front());
                @(negedge clk);
                bus.rx_ready = 1'b0;
            end
        join
        model_rx(8'h05, 1'b1, 1'b1);
        repeat (4) @(negedge clk);
        check_flags("t3b");
        drain("t3b");

        // 4: framing error then line held low
        @(negedge clk);
        send_byte(8'h55, 1'b0, BT);
        model_rx(8'h55, 1'b0, 1'b0);
        repeat (35) @(negedge clk);
        check("t4_busy_low", bus.busy, 1);
        check("t4_no_push", bus.rx_valid, 0);
        check_flags("t4");
        repeat (5) @(negedge clk);
        uart_rx = 1'b1;
        repeat (5) @(negedge clk);
        check("t4_busy_idle", bus.busy, 0);
        send_byte(8'h81, 1'b1, BT);
        model_rx(8'h81, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        drain("t4");
        check_flags("t4_end");

        // 5: short glitch ignored, then a slow (+3%) frame
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (6) @(negedge clk);
        uart_rx = 1'b1;
        repeat (30) @(negedge clk);
        check("t5_glitch_busy", bus.busy, 0);
        check("t5_glitch_valid", bus.rx_valid, 0);
        check_flags("t5_glitch");
        @(negedge clk);
        send_byte(8'hC3, 1'b1, 165);
        model_rx(8'hC3, 1'b1, 1'b0);
        repeat (6) @(negedge clk);
        drain("t5");

        // random bursts with the consumer stalled
        for (int r = 0; r < 4; r++) begin
            n = $urandom_range(1, 6);
            @(negedge clk);
            for (int i = 0; i < n; i++) begin
                b = 8'($urandom);
                send_byte(b, 1'b1, BT);
                model_rx(b, 1'b1, 1'b0);
            end
            repeat (4) @(negedge clk);
            check_flags("rnd");
            drain("rnd");
        end

        // 6: reset mid-frame with bytes queued
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            b = 8'($urandom);
            send_byte(b, 1'b1, BT);
            model_rx(b, 1'b1, 1'b0);
        end
        @(negedge clk);
        fork
            send_byte(8'h96, 1'b1, BT);
            begin
                #(4 * BT + 80);
                check("t6_busy_pre", bus.busy, 1);
                check("t6_valid_pre", bus.rx_valid, 1);
                rst_n = 1'b0;
                #1;
                check("t6_valid_rst", bus.rx_valid, 0);
                check("t6_busy_rst", bus.busy, 0);
            end
        join
        exp_q.delete();
        repeat (10) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("t6_busy_rel", bus.busy, 0);
        send_byte(8'h7E, 1'b1, BT);
        model_rx(8'h7E, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        drain("t6");
        check_flags("t6");
        check("no_dual_flags", both_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
